output_port_alloc: RTL and testbench

//  Per-output-port switch allocator and link driver, downstream of each input_queue.
//  - Collects the one request bit this output port receives from each of the P input queues.
//  - Round-robin arbitrates and returns a registered grant.
//  - Captures the granted input's flit into a registered link output.
//  - Tracks downstream buffer space with a credit counter fed by the neighbour's flit_rel.
//  The router instantiates one per output port; crossbar select = this block's grant.

---
 rtl/output_port_alloc_pkg.sv | 23 ++
 rtl/output_port_alloc_if.sv | 24 ++
 rtl/output_port_alloc_rr_arbiter.sv | 33 +++
 rtl/output_port_alloc.sv | 112 +++++++++++
 tb/tb_output_port_alloc.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/output_port_alloc_pkg.sv
// Shared types and helpers for the output port allocator: buffer depth,
// credit counter width and one-hot to index conversion (also used by the crossbar).
package output_port_alloc_pkg;

    function automatic int credit_width(input int b);
        return b + 1;
    endfunction

    function automatic int buf_depth(input int b);
        return 1 << b;
    endfunction

    // OR-folding the set bit positions keeps this a flat mux tree for any one-hot input.
    function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = idx | 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/output_port_alloc_if.sv
// Request/grant and link bundle between the input queues, this allocator and the downstream link.
// master = allocator side, slave = input queues / neighbour side.
interface output_port_alloc_if #(
    parameter int FW = 64,
    parameter int P  = 7
) ();
    logic [P-1:0]    req;
    logic [P*FW-1:0] flit_in;
    logic [P-1:0]    grant;
    logic            credit_in;
    logic            flit_out_wr;
    logic [FW-1:0]   flit_out;
    logic            credit_err;

    modport master (
        input  req, flit_in, credit_in,
        output grant, flit_out_wr, flit_out, credit_err
    );

    modport slave (
        output req, flit_in, credit_in,
        input  grant, flit_out_wr, flit_out, credit_err
    );
endinterface

// File: rtl/output_port_alloc_rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from the pointer,
// wrapping P-1 -> 0. Outputs nothing when en is low.
module output_port_alloc_rr_arbiter
    import output_port_alloc_pkg::*;
#(
    parameter int P  = 7,
    parameter int IW = (P > 1) ? $clog2(P) : 1
) (
    input  logic [P-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    input  logic          i_en,
    output logic [P-1:0]  o_onehot,
    output logic [IW-1:0] o_idx
);
    logic w_found;
    int   w_j;

    always_comb begin
        o_onehot = '0;
        w_found  = 1'b0;
        w_j      = 0;
        for (int k = 0; k < P; k++) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= P) w_j = w_j - P;
            if (!w_found && i_en && i_req[w_j]) begin
                w_found       = 1'b1;
                o_onehot[w_j] = 1'b1;
            end
        end
    end

    assign o_idx = IW'(onehot_to_idx(32'(o_onehot)));
endmodule

// File: rtl/output_port_alloc.sv
// Per-output-port switch allocator with registered round-robin grant, link register and
// credit tracking. Optional stall counter enabled by defining OPA_STALL_CNT_EN.
module output_port_alloc
    import output_port_alloc_pkg::*;
#(
    parameter int FW = 64,
    parameter int P  = 7,
    parameter int B  = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    output_port_alloc_if.master  bus
`ifdef OPA_STALL_CNT_EN
    ,
    output logic [15:0]          o_stall_cnt
`endif
);
    localparam int IW    = (P > 1) ? $clog2(P) : 1;
    localparam int CW    = credit_width(B);
    localparam int DEPTH = buf_depth(B);

    logic [IW-1:0] r_ptr;
    logic [CW-1:0] r_credits;
    logic [P-1:0]  r_grant;
    logic          r_flit_out_wr;
    logic [FW-1:0] r_flit_out;
    logic          r_credit_err;

    logic          w_eligible;
    logic [P-1:0]  w_win_oh;
    logic [IW-1:0] w_win_idx;
    logic [FW-1:0] w_sel_flit;
    logic          w_dec;
    logic          w_inc;

    assign w_eligible = (|bus.req) && (r_credits != '0);

    output_port_alloc_rr_arbiter #(.P(P), .IW(IW)) u_arb (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .i_en     (w_eligible),
        .o_onehot (w_win_oh),
        .o_idx    (w_win_idx)
    );

    // Crossbar leg: the registered grant selects which input's flit is launched next edge.
    always_comb begin
        w_sel_flit = '0;
        for (int i = 0; i < P; i++) begin
            if (r_grant[i]) w_sel_flit = bus.flit_in[i*FW +: FW];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            r_grant <= w_win_oh;
            if (w_eligible) begin
                r_ptr <= (w_win_idx == IW'(P - 1)) ? '0 : w_win_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_flit_out_wr <= 1'b0;
            r_flit_out    <= '0;
        end else begin
            r_flit_out_wr <= |r_grant;
            if (|r_grant) r_flit_out <= w_sel_flit;
        end
    end

    // Credit is reserved on the edge that issues the grant, not when the flit leaves.
    assign w_dec = w_eligible;
    assign w_inc = bus.credit_in;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_credits    <= CW'(DEPTH);
            r_credit_err <= 1'b0;
        end else begin
            if (w_dec && !w_inc) begin
                r_credits <= r_credits - 1'b1;
            end else if (w_inc && !w_dec) begin
                if (r_credits == CW'(DEPTH)) r_credit_err <= 1'b1;
                else                         r_credits    <= r_credits + 1'b1;
            end
        end
    end

`ifdef OPA_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
        end else if ((|bus.req) && (r_credits == '0) && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

    assign bus.grant       = r_grant;
    assign bus.flit_out_wr = r_flit_out_wr;
    assign bus.flit_out    = r_flit_out;
    assign bus.credit_err  = r_credit_err;
endmodule

// File: tb/tb_output_port_alloc.sv
// Directed bench for output_port_alloc: reset, single request, round-robin order,
// credit exhaustion/return, simultaneous credit events and (optionally) the stall counter.
`timescale 1ns/1ps
module tb_output_port_alloc;
    localparam int FW = 64;
    localparam int P  = 7;
    localparam int B  = 4;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    output_port_alloc_if #(.FW(FW), .P(P)) bus ();

`ifdef OPA_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    output_port_alloc #(.FW(FW), .P(P), .B(B)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.master)
`ifdef OPA_STALL_CNT_EN
        ,
        .o_stall_cnt (stall_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the active edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        bus.req = '0;
        bus.credit_in = 1'b0;
        step();
        step();
        i_rst = 1'b0;
    endtask

    // One request from input 0, dropped in its grant cycle.
    task automatic one_grant(input string tag);
        bus.req[0] = 1'b1;
        step();
        chk(tag, 64'(bus.grant), 64'h1);
        bus.req[0] = 1'b0;
    endtask

    initial begin
        bus.req       = '0;
        bus.flit_in   = '0;
        bus.credit_in = 1'b0;
        for (int i = 0; i < P; i++) bus.flit_in[i*FW +: FW] = 64'h100 + 64'(i);
        do_reset();

        // Reset state
        repeat (4) step();
        chk("rst_grant", 64'(bus.grant), 64'h0);
        chk("rst_wr", 64'(bus.flit_out_wr), 64'h0);
        chk("rst_flit", bus.flit_out, 64'h0);
        chk("rst_credits", 64'(dut.r_credits), 64'd16);
        chk("rst_err", 64'(bus.credit_err), 64'h0);

        // Single requester
        bus.flit_in[2*FW +: FW] = 64'hA5;
        bus.req[2] = 1'b1;
        chk("single_no_comb_grant", 64'(bus.grant), 64'h0);
        step();
        chk("single_grant", 64'(bus.grant), 64'b0000100);
        chk("single_wr_early", 64'(bus.flit_out_wr), 64'h0);
        bus.req[2] = 1'b0;
        step();
        chk("single_grant_once", 64'(bus.grant), 64'h0);
        chk("single_wr", 64'(bus.flit_out_wr), 64'h1);
        chk("single_flit", bus.flit_out, 64'hA5);
        chk("single_credits", 64'(dut.r_credits), 64'd15);
        step();
        chk("single_wr_drop", 64'(bus.flit_out_wr), 64'h0);
        chk("single_flit_hold", bus.flit_out, 64'hA5);

        // Round robin from ptr=0
        do_reset();
        bus.req = 7'b1000101;
        step();
        chk("rr_g0", 64'(bus.grant), 64'b0000001);
        bus.req[0] = 1'b0;
        step();
        chk("rr_g2", 64'(bus.grant), 64'b0000100);
        chk("rr_flit0", bus.flit_out, 64'h100);
        bus.req[2] = 1'b0;
        step();
        chk("rr_g6", 64'(bus.grant), 64'b1000000);
        chk("rr_flit2", bus.flit_out, 64'hA5);
        bus.req[6] = 1'b0;
        chk("rr_ptr", 64'(dut.r_ptr), 64'h0);
        step();
        chk("rr_flit6", bus.flit_out, 64'h106);
        chk("rr_idle", 64'(bus.grant), 64'h0);

        // Credit exhaustion and return
        do_reset();
        for (int n = 0; n < 16; n++) one_grant("exh_grant");
        chk("exh_credits0", 64'(dut.r_credits), 64'd0);
        bus.req[0] = 1'b1;
        step();
        chk("exh_blocked1", 64'(bus.grant), 64'h0);
        step();
        chk("exh_blocked2", 64'(bus.grant), 64'h0);
        bus.credit_in = 1'b1;
        step();
        bus.credit_in = 1'b0;
        chk("exh_pulse_plus1", 64'(bus.grant), 64'h0);
        chk("exh_credits1", 64'(dut.r_credits), 64'd1);
        step();
        chk("exh_pulse_plus2", 64'(bus.grant), 64'h1);
        bus.req[0] = 1'b0;
        chk("exh_credits_back0", 64'(dut.r_credits), 64'd0);

        // Simultaneous grant and credit return, then overflow
        do_reset();
        for (int n = 0; n < 11; n++) one_grant("sim_fill");
        chk("sim_credits5", 64'(dut.r_credits), 64'd5);
        bus.req[3] = 1'b1;
        bus.credit_in = 1'b1;
        step();
        bus.req[3] = 1'b0;
        bus.credit_in = 1'b0;
        chk("sim_grant", 64'(bus.grant), 64'b0001000);
        chk("sim_credits_hold", 64'(dut.r_credits), 64'd5);
        bus.credit_in = 1'b1;
        repeat (11) step();
        chk("sim_credits16", 64'(dut.r_credits), 64'd16);
        chk("sim_err_clear", 64'(bus.credit_err), 64'h0);
        step();
        bus.credit_in = 1'b0;
        chk("ovf_credits", 64'(dut.r_credits), 64'd16);
        chk("ovf_err", 64'(bus.credit_err), 64'h1);
        repeat (3) step();
        chk("ovf_err_sticky", 64'(bus.credit_err), 64'h1);

        // Reset mid-operation drops in-flight grant/write
        bus.req[5] = 1'b1;
        step();
        chk("mid_grant", 64'(bus.grant), 64'b0100000);
        bus.req[5] = 1'b0;
        i_rst = 1'b1;
        #1;
        chk("mid_rst_grant", 64'(bus.grant), 64'h0);
        chk("mid_rst_wr", 64'(bus.flit_out_wr), 64'h0);
        chk("mid_rst_credits", 64'(dut.r_credits), 64'd16);
        chk("mid_rst_err", 64'(bus.credit_err), 64'h0);
        step();
        i_rst = 1'b0;

`ifdef OPA_STALL_CNT_EN
        do_reset();
        for (int n = 0; n < 16; n++) one_grant("stall_fill");
        chk("stall_zero", 64'(stall_cnt), 64'd0);
        bus.req[1] = 1'b1;
        repeat (10) step();
        chk("stall_cnt10", 64'(stall_cnt), 64'd10);
        chk("stall_no_grant", 64'(bus.grant), 64'h0);
        bus.req[1] = 1'b0;
        step();
        chk("stall_hold", 64'(stall_cnt), 64'd10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
